systolic_feeder: RTL

- Drives the operand side of the PE_ROW×PE_COL systolic array and collects its result bus.
- Accepts one operand beat per cycle on a valid/ready stream: one 32-bit data word per row and one 32-bit weight word per column.
- Applies the diagonal skew the array needs, then flushes the array and captures the per-row results.
- Returns the results on a valid/ready output stream. Sits between the operand buffer/DMA and the array.

---
 rtl/systolic_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand skew, flush sequencing and result capture in front of a PE_ROW x PE_COL systolic array.
// Optional FEEDER_SKEW_EN: lane k is delayed k+1 cycles; undefined, every lane is delayed one cycle.
module systolic_feeder #(
  parameter int PE_ROW  = 4,
  parameter int PE_COL  = 4,
  parameter int RES_LAT = 1,
  parameter int K_MAX   = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PE_ROW*32-1:0] s_data,
  input  logic [PE_COL*32-1:0] s_weight,
  input  logic                 s_last,
  output logic                 arr_mode,
  output logic                 arr_clear,
  output logic [PE_ROW*32-1:0] arr_data,
  output logic [PE_COL*32-1:0] arr_weight,
  input  logic [PE_ROW*32-1:0] arr_result,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PE_ROW*32-1:0] m_result,
  output logic                 busy
);
  // state | meaning
  // IDLE  | waiting for the first beat of a job
  // FEED  | streaming beats (bubbles become zero vectors)
  // FLUSH | shifting zeros until the result bus settles
  // OUT   | holding captured results until m_ready
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, OUT} state_t;

  localparam int F  = PE_ROW + PE_COL - 1 + RES_LAT;
  localparam int CW = $clog2(K_MAX) + 1;
  localparam int FW = $clog2(F) + 1;
  localparam logic [CW-1:0] K_LAST = CW'(K_MAX);
  localparam logic [FW-1:0] F_LOAD = FW'(F - 1);

  state_t state, state_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic [FW-1:0] flush_cnt, flush_cnt_nx;
  logic err_overrun, err_set;
  logic accept, capture;
  logic [PE_ROW*32-1:0] lane_data;
  logic [PE_COL*32-1:0] lane_weight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      err_overrun <= 1'b0;
      m_result    <= '0;
    end else begin
      state       <= state_nx;
      beat_cnt    <= beat_cnt_nx;
      flush_cnt   <= flush_cnt_nx;
      err_overrun <= err_overrun | err_set;
      if (capture) m_result <= arr_result;
    end
  end

  always_comb begin
    state_nx     = state;
    beat_cnt_nx  = beat_cnt;
    flush_cnt_nx = flush_cnt;
    err_set      = 1'b0;
    capture      = 1'b0;
    accept       = 1'b0;
    s_ready      = 1'b0;
    arr_clear    = 1'b0;
    arr_mode     = 1'b0;
    m_valid      = 1'b0;
    unique case (state)
      IDLE: begin
        // reset also parks the FSM here, so gate ready with it
        s_ready = reset;
        accept  = s_valid && reset;
        if (accept) begin
          arr_clear    = 1'b1;
          beat_cnt_nx  = CW'(1);
          flush_cnt_nx = F_LOAD;
          state_nx     = s_last ? FLUSH : FEED;
        end
      end
      FEED: begin
        s_ready  = 1'b1;
        arr_mode = 1'b1;
        accept   = s_valid;
        if (accept) begin
          beat_cnt_nx = beat_cnt + 1'b1;
          if (s_last || beat_cnt_nx == K_LAST) begin
            state_nx     = FLUSH;
            flush_cnt_nx = F_LOAD;
            err_set      = !s_last;
          end
        end
      end
      FLUSH: begin
        arr_mode = 1'b1;
        if (flush_cnt == '0) begin
          capture  = 1'b1;
          state_nx = OUT;
        end else begin
          flush_cnt_nx = flush_cnt - 1'b1;
        end
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign lane_data   = accept ? s_data : '0;
  assign lane_weight = accept ? s_weight : '0;

  for (genvar i = 0; i < PE_ROW; i++) begin : g_row
`ifdef FEEDER_SKEW_EN
    localparam int D = i + 1;
`else
    localparam int D = 1;
`endif
    logic [31:0] pipe [D];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < D; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= lane_data[i*32 +: 32];
        for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign arr_data[i*32 +: 32] = pipe[D-1];
  end

  for (genvar j = 0; j < PE_COL; j++) begin : g_col
`ifdef FEEDER_SKEW_EN
    localparam int D = j + 1;
`else
    localparam int D = 1;
`endif
    logic [31:0] pipe [D];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < D; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= lane_weight[j*32 +: 32];
        for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign arr_weight[j*32 +: 32] = pipe[D-1];
  end

endmodule
